isr_entry_unit: RTL and testbench
=================================

Name: isr_entry_unit

Overview:
- Sits directly downstream of the interrupt controller and consumes its jisr and il outputs.
- Owns the special-purpose registers SR, ESR, ECA, EPC, EDATA, MODE and EMODE, and feeds SR back to the interrupt controller.
- On a committed interrupt it saves state, clears SR, enters system mode and redirects fetch to the ISR entry; on eret it restores state.
- A small FSM holds off further commits while the pipeline flushes after a redirect.

Parameters:
- SISR, 32'h0000_0000, ISR entry address driven on redirect_pc for an interrupt.
- REPEAT_MASK, 23'h1F_0000, per-cause-index flag. 1 = repeat-type (EPC gets pc_cur); 0 = continue-type (EPC gets pc_next).
- FLUSH_CYCLES, 2, cycles spent in FLUSH after any redirect. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ue  in  1  instruction in the commit stage commits this cycle.
- jisr  in  1  jump-to-ISR request from the interrupt controller.
- il  in  5  interrupt level (index of the highest-priority active cause), 0..22.
- ca  in  23  raw cause vector, as presented to the interrupt controller.
- pc_cur  in  32  PC of the committing instruction.
- pc_next  in  32  architectural next PC of the committing instruction.
- ea  in  32  effective address of the committing memory access.
- eret  in  1  committing instruction is eret.
- movg2s  in  1  committing instruction writes an SPR.
- sa  in  3  SPR address: 0 SR, 1 ESR, 2 ECA, 3 EPC, 4 EDATA, 5 EMODE, 6–7 reserved.
- gpr_din  in  32  write data for movg2s.
- spr_dout  out  32  combinational read of SPR[sa]; reserved addresses read 0.
- sr  out  32  current SR, fed to the interrupt controller.
- mode  out  1  0 = system, 1 = user.
- redirect  out  1  one-cycle fetch-redirect pulse.
- redirect_pc  out  32  target PC, valid while redirect = 1.
- flushing  out  1  high while in FLUSH; the pipeline must hold ue = 0.

Behaviour:
- **Reset (async, rst = 1):**
  - SR, ESR, ECA, EPC, EDATA = 0; MODE = 0; EMODE = 0.
  - redirect = 0; redirect_pc = 0; flushing = 0.
  - FSM = RUN; flush counter = 0.
- **FSM states:** RUN and FLUSH.
- **In RUN, event priority per cycle (only when ue = 1):** jisr > eret > movg2s. At most one event acts.
- **jisr & ue:**
  - ESR ← SR; SR ← 0.
  - ECA ← ca; EDATA ← ea.
  - EPC ← REPEAT_MASK[il] ? pc_cur : pc_next.
  - EMODE ← MODE; MODE ← 0.
  - redirect = 1 and redirect_pc = SISR in the next cycle.
  - Go to FLUSH.
- **Level 0 (reset cause):** il = 0 with jisr follows the same path. EPC takes pc_next unless REPEAT_MASK[0] = 1.
- **Out-of-range il (23..31):** treated as continue-type.
- **eret & ue (no jisr):**
  - SR ← ESR; MODE ← EMODE.
  - redirect = 1 and redirect_pc = EPC (the pre-update EPC value) in the next cycle.
  - Go to FLUSH.
- **movg2s & ue (no jisr, no eret):**
  - SPR[sa] ← gpr_din at the edge; writes to 6–7 are dropped.
  - sa = 5 writes EMODE ← gpr_din[0].
  - No redirect.
  - A new SR value is visible on the sr output the next cycle.
- **FLUSH:**
  - redirect is high only in the first cycle.
  - flushing = 1 for exactly FLUSH_CYCLES cycles, counted by the flush counter; then return to RUN.
  - jisr, eret and movg2s are ignored even if ue = 1; the verification bench flags ue = 1 here as a protocol error.
- **Same-cycle read and write:** spr_dout shows the pre-write value when a movg2s to the same address occurs in the same cycle (no bypass).
- **jisr & eret together:** jisr wins. ESR captures the current SR, not the ESR that eret would have restored.
- **Reset mid-FLUSH:** returns to RUN immediately; redirect drops asynchronously.
- **jisr with ue = 0:** no effect. The request must be re-presented at commit.
- **Latency:** register updates take effect at edge N for an event at N. redirect is registered and asserted in cycle N+1.

Decomposition:
- Shared package holds:
  - SPR address constants (SPR_SR = 3'd0 … SPR_EMODE = 3'd5).
  - Cause-index width (23) and il width (5).
  - FSM state encoding (ST_RUN, ST_FLUSH).
  - Default REPEAT_MASK constant, shared with the interrupt controller's priority numbering.
- One natural sub-module, flush_timer: a load/decrement counter with a done flag, driving the FLUSH exit.
- The SPR file itself stays inline.

Test Plan:
1. **Reset:** rst high mid-FLUSH → all SPRs 0, mode = 0, redirect = 0, flushing = 0 immediately; first ue = 1 after release is accepted.
2. **Continue interrupt:**
   - Stimulus: SR = 32'h0060_FFFE, MODE = 1, ue = 1, jisr = 1, il = 21, ca = 23'h20_0000, pc_cur = 32'h100, pc_next = 32'h104, ea = 32'h2000.
   - Response: ESR = 32'h0060_FFFE, SR = 0, ECA = 23'h20_0000, EPC = 32'h104, EDATA = 32'h2000, EMODE = 1, MODE = 0.
   - Next cycle: redirect = 1, redirect_pc = SISR; flushing high for 2 cycles.
3. **Repeat interrupt:** il = 17, pc_cur = 32'h300, pc_next = 32'h304 → EPC = 32'h300.
4. **eret:** after case 2, movg2s sa = 3 with 32'h400, then eret → SR = 32'h0060_FFFE, MODE = 1, redirect_pc = 32'h400.
5. **Priority and ignore rules:**
   - jisr + eret + movg2s together → only the interrupt path acts.
   - During FLUSH, ue = 1 with movg2s sa = 0 value 32'hFFFF → SR unchanged at 0.
6. **Read-during-write and reserved addresses:** movg2s sa = 2 while reading sa = 2 → spr_dout shows the old ECA that cycle and the new value the next. sa = 6 read → 0.

Source files
------------

// File: rtl/isr_entry_unit_pkg.sv
// Shared constants and types for the ISR entry unit: SPR addresses,
// cause/level widths, FSM state encoding and the repeat-type cause mask.
package isr_entry_unit_pkg;

  localparam int CAUSE_W = 23;
  localparam int IL_W    = 5;

  typedef logic [2:0] spr_addr_t;

  localparam spr_addr_t SPR_SR    = 3'd0;
  localparam spr_addr_t SPR_ESR   = 3'd1;
  localparam spr_addr_t SPR_ECA   = 3'd2;
  localparam spr_addr_t SPR_EPC   = 3'd3;
  localparam spr_addr_t SPR_EDATA = 3'd4;
  localparam spr_addr_t SPR_EMODE = 3'd5;

  // FSM state encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Cause indices whose handler must re-execute the faulting instruction.
  // Numbering matches the interrupt controller's priority order.
  localparam logic [CAUSE_W-1:0] DEFAULT_REPEAT_MASK = 23'h1F_0000;

  // Which single event the commit stage performs this cycle
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_JISR   = 2'd1,
    EV_ERET   = 2'd2,
    EV_MOVG2S = 2'd3
  } event_t;

  // Levels beyond the cause vector are treated as continue-type.
  function automatic logic is_repeat(input logic [CAUSE_W-1:0] mask,
                                     input logic [IL_W-1:0]    il);
    if (il < IL_W'(CAUSE_W)) return mask[il];
    return 1'b0;
  endfunction

endpackage

// File: rtl/isr_entry_unit_flush_timer.sv
// Load/decrement counter that times the pipeline flush after a redirect.
// done is high while the count sits at 1, i.e. during the last flush cycle.
module isr_entry_unit_flush_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/isr_entry_unit.sv
// ISR entry unit: owns SR/ESR/ECA/EPC/EDATA/MODE/EMODE, saves state and
// redirects fetch to the ISR on a committed interrupt, restores on eret,
// and holds a FLUSH state for FLUSH_CYCLES cycles after every redirect.
//
// Commit handshake: the pipeline presents an instruction with ue = 1 in the
// cycle it commits; this unit accepts it in RUN only. While flushing = 1 the
// pipeline must keep ue = 0, and anything presented then is ignored.
module isr_entry_unit
  import isr_entry_unit_pkg::*;
#(
  parameter logic [31:0]         SISR         = 32'h0000_0000,
  parameter logic [CAUSE_W-1:0]  REPEAT_MASK  = DEFAULT_REPEAT_MASK,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ue,
  input  logic               jisr,
  input  logic [IL_W-1:0]    il,
  input  logic [CAUSE_W-1:0] ca,
  input  logic [31:0]        pc_cur,
  input  logic [31:0]        pc_next,
  input  logic [31:0]        ea,
  input  logic               eret,
  input  logic               movg2s,
  input  logic [2:0]         sa,
  input  logic [31:0]        gpr_din,
  output logic [31:0]        spr_dout,
  output logic [31:0]        sr,
  output logic               mode,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               flushing,
  output logic [0:0]         dbg_state
);

  logic [0:0]         state;
  event_t             ev;
  logic               start_flush;
  logic               flush_done;

  logic [31:0]        sr_q;
  logic [31:0]        esr_q;
  logic [CAUSE_W-1:0] eca_q;
  logic [31:0]        epc_q;
  logic [31:0]        edata_q;
  logic               mode_q;
  logic               emode_q;

  // Pick the one event that acts this cycle: jisr > eret > movg2s, RUN only
  always_comb begin
    ev = EV_NONE;
    if ((state == ST_RUN) && ue) begin
      if (jisr)        ev = EV_JISR;
      else if (eret)   ev = EV_ERET;
      else if (movg2s) ev = EV_MOVG2S;
    end
  end

  assign start_flush = (ev == EV_JISR) || (ev == EV_ERET);

  isr_entry_unit_flush_timer #(
    .W(4)
  ) u_flush_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (start_flush),
    .load_val (4'(FLUSH_CYCLES)),
    .dec      (state == ST_FLUSH),
    .done     (flush_done)
  );

  // RUN/FLUSH state: enter FLUSH on any redirect, leave when the timer expires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (start_flush) state <= ST_FLUSH;
        ST_FLUSH: if (flush_done)  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // Registered one-cycle redirect pulse and its target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= 32'h0;
    end else begin
      redirect <= start_flush;
      if (ev == EV_JISR)      redirect_pc <= SISR;
      else if (ev == EV_ERET) redirect_pc <= epc_q;
    end
  end

  // SPR file: interrupt save, eret restore, or software write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= 32'h0;
      esr_q   <= 32'h0;
      eca_q   <= '0;
      epc_q   <= 32'h0;
      edata_q <= 32'h0;
      mode_q  <= 1'b0;
      emode_q <= 1'b0;
    end else begin
      case (ev)
        EV_JISR: begin
          esr_q   <= sr_q;
          sr_q    <= 32'h0;
          eca_q   <= ca;
          edata_q <= ea;
          epc_q   <= is_repeat(REPEAT_MASK, il) ? pc_cur : pc_next;
          emode_q <= mode_q;
          mode_q  <= 1'b0;
        end
        EV_ERET: begin
          sr_q   <= esr_q;
          mode_q <= emode_q;
        end
        EV_MOVG2S: begin
          case (sa)
            SPR_SR:    sr_q    <= gpr_din;
            SPR_ESR:   esr_q   <= gpr_din;
            SPR_ECA:   eca_q   <= gpr_din[CAUSE_W-1:0];
            SPR_EPC:   epc_q   <= gpr_din;
            SPR_EDATA: edata_q <= gpr_din;
            SPR_EMODE: emode_q <= gpr_din[0];
            default:   ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Combinational SPR read, no write bypass; reserved addresses read zero
  always_comb begin
    spr_dout = 32'h0;
    case (sa)
      SPR_SR:    spr_dout = sr_q;
      SPR_ESR:   spr_dout = esr_q;
      SPR_ECA:   spr_dout = {{(32-CAUSE_W){1'b0}}, eca_q};
      SPR_EPC:   spr_dout = epc_q;
      SPR_EDATA: spr_dout = edata_q;
      SPR_EMODE: spr_dout = {31'h0, emode_q};
      default:   spr_dout = 32'h0;
    endcase
  end

  assign sr        = sr_q;
  assign mode      = mode_q;
  assign flushing  = (state == ST_FLUSH);
  assign dbg_state = state;

endmodule

// File: tb/tb_isr_entry_unit.sv
// Bench for isr_entry_unit: directed cases with literal expectations, then
// randomized commits checked every cycle against a behavioural model.
module tb_isr_entry_unit;

  localparam int          FC    = 2;
  localparam logic [31:0] SISR  = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        ue = 0, jisr = 0, eret = 0, movg2s = 0;
  logic [4:0]  il = 0;
  logic [22:0] ca = 0;
  logic [31:0] pc_cur = 0, pc_next = 0, ea = 0, gpr_din = 0;
  logic [2:0]  sa = 0;
  logic [31:0] spr_dout, sr, redirect_pc;
  logic        mode, redirect, flushing;
  logic [0:0]  dbg_state;

  isr_entry_unit #(.SISR(SISR), .REPEAT_MASK(23'h1F_0000), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .ue(ue), .jisr(jisr), .il(il), .ca(ca),
    .pc_cur(pc_cur), .pc_next(pc_next), .ea(ea), .eret(eret), .movg2s(movg2s),
    .sa(sa), .gpr_din(gpr_din), .spr_dout(spr_dout), .sr(sr), .mode(mode),
    .redirect(redirect), .redirect_pc(redirect_pc), .flushing(flushing),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int proto_cnt = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // SPRs held as an 8-entry array indexed by address; 6/7 stay zero.
  logic [31:0] m_spr[8];
  logic        m_mode;
  int          m_flush_left;
  logic        m_redirect;
  logic [31:0] m_redirect_pc;
  logic [31:0] repeat_mask32 = 32'h001F_0000;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_spr[i] = 32'h0;
    m_mode = 0; m_flush_left = 0; m_redirect = 0; m_redirect_pc = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    m_redirect = 0;
    if (m_flush_left > 0) begin
      if (ue) proto_cnt++;
      m_flush_left--;
    end else if (ue && jisr) begin
      m_spr[1] = m_spr[0];
      m_spr[0] = 0;
      m_spr[2] = {9'h0, ca};
      m_spr[4] = ea;
      m_spr[3] = repeat_mask32[il] ? pc_cur : pc_next;
      m_spr[5] = {31'h0, m_mode};
      m_mode = 0;
      m_redirect = 1; m_redirect_pc = SISR; m_flush_left = FC;
    end else if (ue && eret) begin
      m_redirect = 1; m_redirect_pc = m_spr[3]; m_flush_left = FC;
      m_spr[0] = m_spr[1];
      m_mode = m_spr[5][0];
    end else if (ue && movg2s) begin
      if (sa == 3'd2)      m_spr[2] = gpr_din & 32'h007F_FFFF;
      else if (sa == 3'd5) m_spr[5] = gpr_din & 32'h1;
      else if (sa < 3'd5)  m_spr[sa] = gpr_din;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // scoreboard: compare DUT outputs with the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("sr", sr, m_spr[0]);
        check("mode", {31'h0, mode}, {31'h0, m_mode});
        check("flushing", {31'h0, flushing}, {31'h0, (m_flush_left > 0)});
        check("redirect", {31'h0, redirect}, {31'h0, m_redirect});
        check("spr_dout", spr_dout, m_spr[sa]);
        if (m_redirect) check("redirect_pc", redirect_pc, m_redirect_pc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ue = 0; jisr = 0; eret = 0; movg2s = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    sa = a;
    #1;
    v = spr_dout;
  endtask

  task automatic do_mov(input logic [2:0] a, input logic [31:0] d);
    ue = 1; movg2s = 1; sa = a; gpr_din = d;
    step();
    idle();
  endtask

  task automatic do_eret();
    ue = 1; eret = 1;
    step();
    idle();
  endtask

  task automatic do_jisr(input logic [4:0] l, input logic [22:0] c,
                         input logic [31:0] pcc, input logic [31:0] pcn,
                         input logic [31:0] e);
    ue = 1; jisr = 1; il = l; ca = c; pc_cur = pcc; pc_next = pcn; ea = e;
    step();
    idle();
  endtask

  logic [31:0] v;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_sr", sr, 32'h0);
    check("rst_mode", {31'h0, mode}, 32'h0);
    check("rst_redirect", {31'h0, redirect}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_flushing", {31'h0, flushing}, 32'h0);
    for (int a = 1; a < 6; a++) begin
      rd(3'(a), v);
      check("rst_spr", v, 32'h0);
    end
    rst = 0;
    cmp_en = 1;
    step();

    // setup: SR = 0060_FFFE, MODE = 1 via EMODE/ESR writes and eret
    do_mov(3'd5, 32'h1);
    do_mov(3'd1, 32'h0060_FFFE);
    do_eret();
    check("setup_sr", sr, 32'h0060_FFFE);
    check("setup_mode", {31'h0, mode}, 32'h1);
    check("setup_redirect_pc", redirect_pc, 32'h0);
    repeat (FC) step();

    // continue-type interrupt
    do_jisr(5'd21, 23'h20_0000, 32'h100, 32'h104, 32'h2000);
    check("cont_redirect", {31'h0, redirect}, 32'h1);
    check("cont_redirect_pc", redirect_pc, SISR);
    check("cont_flushing1", {31'h0, flushing}, 32'h1);
    check("cont_sr", sr, 32'h0);
    check("cont_mode", {31'h0, mode}, 32'h0);
    rd(3'd1, v); check("cont_esr", v, 32'h0060_FFFE);
    rd(3'd2, v); check("cont_eca", v, 32'h0020_0000);
    rd(3'd3, v); check("cont_epc", v, 32'h104);
    rd(3'd4, v); check("cont_edata", v, 32'h2000);
    rd(3'd5, v); check("cont_emode", v, 32'h1);
    step();
    check("cont_flushing2", {31'h0, flushing}, 32'h1);
    check("cont_redirect_drop", {31'h0, redirect}, 32'h0);
    step();
    check("cont_flush_end", {31'h0, flushing}, 32'h0);

    // eret to a software-written EPC
    do_mov(3'd3, 32'h400);
    do_eret();
    check("eret_sr", sr, 32'h0060_FFFE);
    check("eret_mode", {31'h0, mode}, 32'h1);
    check("eret_redirect_pc", redirect_pc, 32'h400);
    repeat (FC) step();

    // repeat-type interrupt
    do_jisr(5'd17, 23'h2, 32'h300, 32'h304, 32'h0);
    rd(3'd3, v); check("rep_epc", v, 32'h300);
    repeat (FC) step();

    // jisr + eret + movg2s together: interrupt path only
    do_mov(3'd0, 32'h1234);
    ue = 1; jisr = 1; eret = 1; movg2s = 1; sa = 3'd0; gpr_din = 32'hFFFF;
    il = 5'd3; ca = 23'h7; pc_cur = 32'h500; pc_next = 32'h504; ea = 32'h0;
    step();
    idle();
    check("prio_sr", sr, 32'h0);
    check("prio_redirect_pc", redirect_pc, SISR);
    rd(3'd1, v); check("prio_esr", v, 32'h1234);
    rd(3'd3, v); check("prio_epc", v, 32'h504);
    // commit during FLUSH is ignored
    ue = 1; movg2s = 1; sa = 3'd0; gpr_din = 32'hFFFF;
    step();
    idle();
    check("flush_ignore_sr", sr, 32'h0);
    repeat (FC - 1) step();

    // read-during-write shows the old value; reserved addresses read zero
    sa = 3'd2; ue = 1; movg2s = 1; gpr_din = 32'h0055_AAAA;
    #1;
    check("rdw_old", spr_dout, 32'h7);
    step();
    idle();
    check("rdw_new", spr_dout, 32'h0055_AAAA);
    do_mov(3'd6, 32'hDEAD);
    rd(3'd6, v); check("reserved6", v, 32'h0);
    rd(3'd7, v); check("reserved7", v, 32'h0);

    // out-of-range level and level 0 are continue-type
    do_jisr(5'd25, 23'h1, 32'h600, 32'h604, 32'h0);
    rd(3'd3, v); check("il25_epc", v, 32'h604);
    repeat (FC) step();
    do_jisr(5'd0, 23'h1, 32'h700, 32'h704, 32'h0);
    rd(3'd3, v); check("il0_epc", v, 32'h704);

    // reset while flushing
    #2;
    rst = 1;
    #1;
    check("rstf_redirect", {31'h0, redirect}, 32'h0);
    check("rstf_flushing", {31'h0, flushing}, 32'h0);
    check("rstf_mode", {31'h0, mode}, 32'h0);
    rd(3'd3, v); check("rstf_epc", v, 32'h0);
    step();
    rst = 0;
    do_mov(3'd0, 32'h5);
    check("post_rst_sr", sr, 32'h5);

    // randomized commits
    for (int n = 0; n < 400; n++) begin
      ue      = ($urandom_range(0, 3) != 0);
      jisr    = ($urandom_range(0, 5) == 0);
      eret    = ($urandom_range(0, 5) == 0);
      movg2s  = ($urandom_range(0, 1) == 0);
      il      = 5'($urandom_range(0, 31));
      ca      = 23'($urandom);
      pc_cur  = $urandom;
      pc_next = $urandom;
      ea      = $urandom;
      sa      = 3'($urandom_range(0, 7));
      gpr_din = $urandom;
      step();
    end
    idle();
    step();
    cmp_en = 0;

    $display("note: commits presented during flush = %0d", proto_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
